// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word-aligned data-memory access with
// optional wait states, upstream stall generation and the MEM/WB register.
module mem_stage #(
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  WB_in,
    input  logic [1:0]  MEM_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  WN_in,
    output logic        stall,
    output logic [1:0]  WB_out,
    output logic [31:0] rdata_out,
    output logic [31:0] alu_out,
    output logic [4:0]  WN_out,
    output logic        misalign
);

    localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [31:0]   mem [0:DEPTH-1];

    logic          mem_op;
    logic          is_store;
    logic          is_load;
    logic          aligned;
    logic          mis_op;
    logic          go;
    logic          done;
    logic          stall_c;
    logic [AW-1:0] idx;
    logic          unused_addr_bits;

    // MEM_in = 11 behaves as a plain store; only 10 produces load data.
    assign mem_op   = (MEM_in != 2'b00);
    assign is_store = MEM_in[0];
    assign is_load  = (MEM_in == 2'b10);
    assign aligned  = (addr_in[1:0] == 2'b00);
    assign mis_op   = mem_op && !aligned;
    assign go       = mem_op && aligned;
    assign idx      = addr_in[AW+1:2];

    assign unused_addr_bits = ^addr_in[31:AW+2];

    // The access completes on the last cycle of its window, i.e. the one cycle it does not stall.
    assign done    = (WAIT_CYCLES == 0) ? go
                                        : (go && (state == S_WAIT) && (cnt == '0));
    assign stall_c = (WAIT_CYCLES != 0) && go && !((state == S_WAIT) && (cnt == '0));
    assign stall   = rst && stall_c;

    // Gating with rst keeps a store that is pending when reset arrives from landing.
    always_ff @(posedge clk) begin
        if (rst && done && is_store) begin
            mem[idx] <= wdata_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            WB_out    <= '0;
            rdata_out <= '0;
            alu_out   <= '0;
            WN_out    <= '0;
            misalign  <= 1'b0;
        end else begin
            if (mis_op) begin
                misalign <= 1'b1;
            end
            if (stall_c) begin
                WB_out    <= '0;
                rdata_out <= '0;
                alu_out   <= '0;
                WN_out    <= '0;
                if (state == S_IDLE) begin
                    state <= S_WAIT;
                    cnt   <= CW'(WAIT_CYCLES - 1);
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end else begin
                WB_out    <= mis_op ? 2'b00 : WB_in;
                rdata_out <= (done && is_load) ? mem[idx] : '0;
                alu_out   <= addr_in;
                WN_out    <= WN_in;
                state     <= S_IDLE;
                cnt       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage: one instance with two wait
// states, one single-cycle instance, both checked against a word-level memory model.
module tb_mem_stage;

    localparam int N = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  wb_in;
    logic [1:0]  mem_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [4:0]  wn_in;

    logic        stall, stall_z;
    logic [1:0]  wb_out, wb_out_z;
    logic [31:0] rdata_out, rdata_out_z;
    logic [31:0] alu_out, alu_out_z;
    logic [4:0]  wn_out, wn_out_z;
    logic        misalign, misalign_z;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] ref_mem  [int];
    logic [31:0] ref_mem0 [int];
    bit          ref_mis;
    bit          ref_mis0;

    mem_stage #(.AW(8), .WAIT_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .WB_in(wb_in), .MEM_in(mem_in), .addr_in(addr_in),
        .wdata_in(wdata_in), .WN_in(wn_in), .stall(stall), .WB_out(wb_out),
        .rdata_out(rdata_out), .alu_out(alu_out), .WN_out(wn_out), .misalign(misalign)
    );

    mem_stage #(.AW(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .WB_in(wb_in), .MEM_in(mem_in), .addr_in(addr_in),
        .wdata_in(wdata_in), .WN_in(wn_in), .stall(stall_z), .WB_out(wb_out_z),
        .rdata_out(rdata_out_z), .alu_out(alu_out_z), .WN_out(wn_out_z), .misalign(misalign_z)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int wordIdx(input logic [31:0] addr);
        return int'((addr >> 2) % 256);
    endfunction

    function automatic logic [31:0] refRead(input int idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return 32'hxxxxxxxx;
    endfunction

    // One operation on the wait-state instance; called right after a negedge.
    task automatic applyStimulus(input logic [1:0] wb, input logic [1:0] mem,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] wn);
        bit          good_mem;
        bit          bad_mem;
        int          n_stall;
        logic [1:0]  exp_wb;
        logic [31:0] exp_rd;
        good_mem = (mem != 2'b00) && (addr % 4 == 0);
        bad_mem  = (mem != 2'b00) && (addr % 4 != 0);
        n_stall  = good_mem ? N : 0;
        exp_wb   = bad_mem ? 2'b00 : wb;
        exp_rd   = (good_mem && mem == 2'b10) ? refRead(wordIdx(addr)) : 32'h0;
        wb_in = wb; mem_in = mem; addr_in = addr; wdata_in = data; wn_in = wn;
        for (int c = 0; c <= n_stall; c++) begin
            #1 checkOutput("stall", 32'(stall), 32'(c < n_stall));
            @(posedge clk); #1;
            if (c < n_stall) begin
                checkOutput("bubble_wb", 32'(wb_out), 32'h0);
            end else begin
                checkOutput("wb_out", 32'(wb_out), 32'(exp_wb));
                checkOutput("rdata_out", rdata_out, exp_rd);
                checkOutput("alu_out", alu_out, addr);
                checkOutput("wn_out", 32'(wn_out), 32'(wn));
            end
            @(negedge clk);
        end
        if (good_mem && mem[0]) ref_mem[wordIdx(addr)] = data;
        if (bad_mem) ref_mis = 1'b1;
        checkOutput("misalign", 32'(misalign), 32'(ref_mis));
    endtask

    // One operation on the single-cycle instance.
    task automatic applyStimulusZero(input logic [1:0] wb, input logic [1:0] mem,
                                     input logic [31:0] addr, input logic [31:0] data,
                                     input logic [4:0] wn);
        bit          good_mem;
        bit          bad_mem;
        logic [31:0] exp_rd;
        good_mem = (mem != 2'b00) && (addr % 4 == 0);
        bad_mem  = (mem != 2'b00) && (addr % 4 != 0);
        exp_rd   = 32'h0;
        if (good_mem && mem == 2'b10)
            exp_rd = ref_mem0.exists(wordIdx(addr)) ? ref_mem0[wordIdx(addr)] : 32'hxxxxxxxx;
        wb_in = wb; mem_in = mem; addr_in = addr; wdata_in = data; wn_in = wn;
        #1 checkOutput("z_stall", 32'(stall_z), 32'h0);
        @(posedge clk); #1;
        checkOutput("z_wb_out", 32'(wb_out_z), bad_mem ? 32'h0 : 32'(wb));
        checkOutput("z_rdata_out", rdata_out_z, exp_rd);
        checkOutput("z_alu_out", alu_out_z, addr);
        checkOutput("z_wn_out", 32'(wn_out_z), 32'(wn));
        if (good_mem && mem[0]) ref_mem0[wordIdx(addr)] = data;
        if (bad_mem) ref_mis0 = 1'b1;
        checkOutput("z_misalign", 32'(misalign_z), 32'(ref_mis0));
        @(negedge clk);
    endtask

    function automatic logic [31:0] randAligned(input int lo, input int hi);
        logic [31:0] upper;
        upper = $urandom;
        return (upper & 32'hFFFF_FC00) | (32'($urandom_range(hi, lo)) << 2);
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  m;
        int          sel;

        clk = 0; rst = 1;
        wb_in = 0; mem_in = 0; addr_in = 0; wdata_in = 0; wn_in = 0;
        ref_mis = 0; ref_mis0 = 0;
        #3 rst = 0;
        #2;
        checkOutput("rst_stall", 32'(stall), 32'h0);
        checkOutput("rst_wb", 32'(wb_out), 32'h0);
        checkOutput("rst_rdata", rdata_out, 32'h0);
        checkOutput("rst_alu", alu_out, 32'h0);
        checkOutput("rst_wn", 32'(wn_out), 32'h0);
        checkOutput("rst_misalign", 32'(misalign), 32'h0);
        checkOutput("rst_z_misalign", 32'(misalign_z), 32'h0);
        @(negedge clk);
        rst = 1;

        // ALU pass-through, then the basic store/load pair
        applyStimulus(2'b10, 2'b00, 32'h0000_1234, 32'h0, 5'd5);
        applyStimulus(2'b00, 2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
        applyStimulus(2'b11, 2'b10, 32'h0000_0010, 32'h0, 5'd9);

        for (int i = 0; i < 16; i++)
            applyStimulus(2'b00, 2'b01, 32'(i * 4), $urandom, 5'd0);

        // Address wrap: word 256 aliases word 0
        applyStimulus(2'b00, 2'b01, 32'h0000_0400, 32'h0000_00A5, 5'd0);
        applyStimulus(2'b10, 2'b10, 32'h0000_0000, 32'h0, 5'd3);

        applyStimulus(2'b11, 2'b10, 32'h0000_0013, 32'h0, 5'd7);
        applyStimulus(2'b11, 2'b11, 32'h0000_0014, 32'h1357_9BDF, 5'd8);
        applyStimulus(2'b11, 2'b10, 32'h0000_0010, 32'h0, 5'd4);
        applyStimulus(2'b11, 2'b10, 32'h0000_0014, 32'h0, 5'd4);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(4, 0);
            d   = $urandom;
            a   = randAligned(0, 15);
            case (sel)
                0: m = 2'b00;
                1: m = 2'b10;
                2: m = 2'b01;
                3: m = 2'b11;
                default: begin
                    m = 2'($urandom_range(3, 1));
                    a = a | 32'($urandom_range(3, 1));
                end
            endcase
            applyStimulus(2'($urandom), m, a, d, 5'($urandom));
        end

        // Reset while a store to word 8 is still waiting
        d = refRead(8);
        wb_in = 2'b00; mem_in = 2'b01; addr_in = 32'h20; wdata_in = ~d; wn_in = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        checkOutput("midrst_stall", 32'(stall), 32'h0);
        checkOutput("midrst_wb", 32'(wb_out), 32'h0);
        checkOutput("midrst_rdata", rdata_out, 32'h0);
        checkOutput("midrst_alu", alu_out, 32'h0);
        checkOutput("midrst_misalign", 32'(misalign), 32'h0);
        mem_in = 2'b00;
        ref_mis = 0;
        @(negedge clk);
        rst = 1;
        applyStimulus(2'b10, 2'b10, 32'h0000_0020, 32'h0, 5'd2);
        applyStimulus(2'b10, 2'b00, 32'h0000_0044, 32'h0, 5'd1);

        // Single-cycle instance from a fresh reset
        rst = 0;
        #1 checkOutput("z_rst_misalign", 32'(misalign_z), 32'h0);
        ref_mis0 = 0;
        @(negedge clk);
        rst = 1;
        applyStimulusZero(2'b00, 2'b01, 32'h0000_0080, 32'hCAFE_F00D, 5'd0);
        applyStimulusZero(2'b10, 2'b10, 32'h0000_0080, 32'h0, 5'd6);
        for (int i = 0; i < 8; i++)
            applyStimulusZero(2'b00, 2'b01, 32'((32 + i) * 4), $urandom, 5'd0);
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(4, 0);
            a   = randAligned(32, 39);
            m   = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b10 : (sel == 2) ? 2'b01 : 2'b11;
            if (sel == 4) a = a | 32'($urandom_range(3, 1));
            applyStimulusZero(2'($urandom), m, a, $urandom, 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
